ika2151_acc_serializer: RTL and testbench
=========================================

Name: ika2151_acc_serializer

Overview:
- Downstream of the operator stage: sums the per-slot carrier outputs into left and right sample accumulators over a 32-slot frame.
- At each frame boundary, saturates each sum to 16-bit signed and converts it to the 13-bit YM3012 floating format (10-bit mantissa, 3-bit exponent).
- Shifts the converted words out on the serial DAC line (SO) during the following frame.

Parameters:
- ACC_W, 19, accumulator width in bits; must hold 32 × 14-bit signed values without overflow.

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_MRST_n  in  1  master reset, asynchronous, active-low
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active-low; all state updates only when low
- i_CYCLE_31  in  1  high during the last slot (31) of the frame
- i_ACC_SNDADD  in  1  current slot is a carrier whose output is summed
- i_ACC_RL  in  2  channel output enables for the current slot; [1]=L, [0]=R
- i_OP_DATA  in  14  signed operator output for the current slot
- o_SO  out  1  serial DAC data

Behaviour:
- Reset (asynchronous, i_MRST_n low):
  - acc_l, acc_r, slot counter, latched words all cleared to 0.
  - o_SO=0.
  - Reset mid-frame drops the partial frame; the serial output emits zeros until a full frame has been latched after reset release.
- All actions below occur on i_EMUCLK rising edges with i_phi1_NCEN_n=0; otherwise all state holds.
- Slot counter:
  - 5-bit, increments every enabled tick and wraps 31→0.
  - Forced to 0 on the tick after i_CYCLE_31 is sampled high, which resynchronises it to the timing generator.
- Accumulation:
  - Per tick, when i_ACC_SNDADD=1, sign-extend i_OP_DATA to ACC_W bits.
  - Add it to acc_l if i_ACC_RL[1]=1, and to acc_r if i_ACC_RL[0]=1.
  - Both enables high adds to both; both low adds nothing.
- Frame boundary (tick with i_CYCLE_31=1):
  - The slot-31 contribution is included in the sum.
  - The result is saturated to [-32768, 32767] (value v) and converted.
  - The converted word is latched into word_l / word_r.
  - The accumulator is then reset to 0; the next frame starts from 0 and does not add to stale contents.
- Float conversion of 16-bit v:
  - s = smallest value in 0..6 such that v[15:s+9] are all equal.
  - mantissa m = v[s+9:s] (10-bit two's complement); exponent e = s+1, range 1..7.
  - Truncation only; no rounding.
- Serial word (16 bits, index k):
  - k=0..2: 0.
  - k=3..12: m[0..9], LSB first.
  - k=13..15: e[0..2], LSB first.
- Serial frame:
  - Slot n=0..15 drives word_l bit k=n; slot n=16..31 drives word_r bit k=n-16.
  - o_SO is registered and updates on the tick that enters slot n.
- Latency: a sample summed in frame F appears on o_SO throughout frame F+1.
- Boundary cases:
  - Accumulator overflow is impossible with ACC_W=19.
  - An out-of-range sum saturates; it never wraps.
  - An i_CYCLE_31 pulse in an unexpected slot still forces latch, clear and counter realignment.

Optional Feature:
- Macro: IKA2151_ACC_PARALLEL_OUT_EN.
- Defined: adds the following outputs.
  - o_EMU_L [15:0] and o_EMU_R [15:0]: the saturated v values, updated on the boundary tick, reset 0.
  - o_EMU_SAMPLE: a 1-tick strobe on the boundary tick.
- Undefined: these ports and their registers do not exist; serial behaviour is identical in both builds.

Test Plan:
- Reset mid-frame after partial sums → o_SO=0 for the remainder of that frame and the whole next frame; first nonzero data appears only after a full post-reset frame.
- One carrier slot, i_OP_DATA=256, RL=2'b10, all other slots silent → next frame word_l: m=256, e=1; o_SO high at slot 11 (m bit 8) and slot 13 (e bit 0), all other L slots 0; R word all zero.
- 1000 on L only → m=500, e=2: check each o_SO bit in slots 0..15.
- 8 slots × 8191 with RL=2'b11 → sum 65528 saturates to 32767 → m=511, e=7 on both L and R.
- 8 slots × -8192 → sum -65536 saturates to -32768 → m=0x200, e=7; verify slots 12, 13, 14, 15 high and all other L bits low.
- IKA2151_ACC_PARALLEL_OUT_EN defined: per-frame sum -1234 on R → o_EMU_R=16'hFB2E with a single o_EMU_SAMPLE pulse; serial output matches the undefined-macro build bit-for-bit.

Source files
------------

// File: rtl/ika2151_acc_serializer.sv
// Purpose : sums per-slot carrier outputs into L/R accumulators over a 32-slot frame, saturates
//           each sum to 16 bits, converts it to the 13-bit YM3012 float and shifts it out on SO.
// Latency : a sample summed in frame F is serialised throughout frame F+1; no backpressure (free-running).
// Ports   : i_EMUCLK/i_MRST_n clock and async active-low reset; i_phi1_NCEN_n active-low tick enable;
//           i_CYCLE_31 last-slot marker; i_ACC_SNDADD/i_ACC_RL/i_OP_DATA per-slot carrier contribution;
//           o_SO serial DAC data (slots 0..15 left word, 16..31 right word).
// Option  : define IKA2151_ACC_PARALLEL_OUT_EN to add o_EMU_L/o_EMU_R (saturated samples) and the
//           o_EMU_SAMPLE boundary strobe; the serial path is identical either way.
module ika2151_acc_serializer #(
    parameter int ACC_W = 19
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_31,
    input  logic        i_ACC_SNDADD,
    input  logic [1:0]  i_ACC_RL,
    input  logic [13:0] i_OP_DATA,
    output logic        o_SO
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
    ,
    output logic [15:0] o_EMU_L,
    output logic [15:0] o_EMU_R,
    output logic        o_EMU_SAMPLE
`endif
);

    // Clamp the accumulator to the signed 16-bit range instead of letting it wrap.
    function automatic logic [15:0] f_sat(input logic [ACC_W-1:0] a);
        if (a[ACC_W-1:15] == {(ACC_W-15){a[15]}}) return a[15:0];
        else if (a[ACC_W-1])                      return 16'h8000;
        else                                      return 16'h7FFF;
    endfunction

    // Float conversion: pick the smallest shift that keeps every dropped upper bit equal to
    // the sign, so the 10-bit mantissa is a faithful two's-complement window. Result {e, m}.
    function automatic logic [12:0] f_float(input logic [15:0] v);
        if      (v[15:9]  == {7{v[15]}}) return {3'd1, v[9:0]};
        else if (v[15:10] == {6{v[15]}}) return {3'd2, v[10:1]};
        else if (v[15:11] == {5{v[15]}}) return {3'd3, v[11:2]};
        else if (v[15:12] == {4{v[15]}}) return {3'd4, v[12:3]};
        else if (v[15:13] == {3{v[15]}}) return {3'd5, v[13:4]};
        else if (v[15:14] == {2{v[15]}}) return {3'd6, v[14:5]};
        else                             return {3'd7, v[15:6]};
    endfunction

    logic             w_en;
    logic [ACC_W-1:0] w_op_ext;
    logic [ACC_W-1:0] w_sum_l;
    logic [ACC_W-1:0] w_sum_r;
    logic [15:0]      w_sat_l;
    logic [15:0]      w_sat_r;
    logic [4:0]       w_cnt_nxt;
    logic [12:0]      w_word;
    logic [15:0]      w_ser;
    logic             w_keep;

    logic [ACC_W-1:0] r_acc_l;
    logic [ACC_W-1:0] r_acc_r;
    logic [4:0]       r_cnt;
    logic [12:0]      r_word_l;
    logic [12:0]      r_word_r;
    logic             r_synced;
    logic             r_so;

    assign w_en     = ~i_phi1_NCEN_n;
    assign w_op_ext = {{(ACC_W-14){i_OP_DATA[13]}}, i_OP_DATA};
    assign w_sum_l  = r_acc_l + ((i_ACC_SNDADD & i_ACC_RL[1]) ? w_op_ext : '0);
    assign w_sum_r  = r_acc_r + ((i_ACC_SNDADD & i_ACC_RL[0]) ? w_op_ext : '0);
    assign w_sat_l  = f_sat(w_sum_l);
    assign w_sat_r  = f_sat(w_sum_r);

    // The slot-31 marker realigns the counter even when it arrives out of turn.
    assign w_cnt_nxt = i_CYCLE_31 ? 5'd0 : r_cnt + 5'd1;

    // SO is registered on the tick entering a slot, so look up the bit for the slot being entered.
    // On the boundary tick the next slot is 0, whose bit is always 0, so the word update is harmless.
    assign w_word = w_cnt_nxt[4] ? r_word_r : r_word_l;
    assign w_ser  = {w_word, 3'b000};

    // After reset the first boundary closes a frame of unknown length; it is only trusted if a
    // full 32 ticks were counted since reset release, otherwise zeros are latched instead.
    assign w_keep = r_synced | (r_cnt == 5'd31);

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_cnt    <= '0;
            r_word_l <= '0;
            r_word_r <= '0;
            r_synced <= 1'b0;
            r_so     <= 1'b0;
        end else if (w_en) begin
            r_cnt <= w_cnt_nxt;
            r_so  <= w_ser[w_cnt_nxt[3:0]];
            if (i_CYCLE_31) begin
                r_word_l <= w_keep ? f_float(w_sat_l) : '0;
                r_word_r <= w_keep ? f_float(w_sat_r) : '0;
                r_acc_l  <= '0;
                r_acc_r  <= '0;
                r_synced <= 1'b1;
            end else begin
                r_acc_l <= w_sum_l;
                r_acc_r <= w_sum_r;
            end
        end
    end

    assign o_SO = r_so;

`ifdef IKA2151_ACC_PARALLEL_OUT_EN
    logic [15:0] r_emu_l;
    logic [15:0] r_emu_r;
    logic        r_emu_sample;

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            r_emu_l      <= '0;
            r_emu_r      <= '0;
            r_emu_sample <= 1'b0;
        end else if (w_en) begin
            r_emu_sample <= i_CYCLE_31;
            if (i_CYCLE_31) begin
                r_emu_l <= w_keep ? w_sat_l : '0;
                r_emu_r <= w_keep ? w_sat_r : '0;
            end
        end
    end

    assign o_EMU_L      = r_emu_l;
    assign o_EMU_R      = r_emu_r;
    assign o_EMU_SAMPLE = r_emu_sample;
`endif

endmodule

// File: tb/tb_ika2151_acc_serializer.sv
// Purpose : directed self-checking bench for ika2151_acc_serializer (serial word contents, saturation,
//           reset mid-frame, tick-enable gating; parallel outputs when the option macro is defined).
// Latency : serial capture of a frame reflects the words latched at the previous frame boundary.
// Stimulus: every enabled tick is preceded by a disabled clock carrying garbage that must be ignored.
module tb_ika2151_acc_serializer;

    logic        clk;
    logic        rst_n;
    logic        ncen_n;
    logic        cycle_31;
    logic        sndadd;
    logic [1:0]  rl;
    logic [13:0] op_data;
    logic        so;
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
    logic [15:0] emu_l;
    logic [15:0] emu_r;
    logic        emu_sample;
    int          sample_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ika2151_acc_serializer #(.ACC_W(19)) dut (
        .i_EMUCLK      (clk),
        .i_MRST_n      (rst_n),
        .i_phi1_NCEN_n (ncen_n),
        .i_CYCLE_31    (cycle_31),
        .i_ACC_SNDADD  (sndadd),
        .i_ACC_RL      (rl),
        .i_OP_DATA     (op_data),
        .o_SO          (so)
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
        ,
        .o_EMU_L       (emu_l),
        .o_EMU_R       (emu_r),
        .o_EMU_SAMPLE  (emu_sample)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Disabled clock with inputs that would corrupt every sum if the enable were ignored.
    task automatic idle_clk();
        ncen_n   = 1'b1;
        cycle_31 = 1'b1;
        sndadd   = 1'b1;
        rl       = 2'b11;
        op_data  = 14'h1FFF;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic c31, input logic add, input logic [1:0] r, input logic [13:0] d);
        idle_clk();
        ncen_n   = 1'b0;
        cycle_31 = c31;
        sndadd   = add;
        rl       = r;
        op_data  = d;
        @(posedge clk);
        #1;
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
        if (emu_sample) sample_cnt++;
`endif
    endtask

    // One 32-slot frame with n_add contributions in slots 0..n_add-1. cap[n] is o_SO while in slot n.
    task automatic frame(input int n_add, input logic [13:0] d, input logic [1:0] r,
                         output logic [31:0] cap);
        cap[0] = so;
        for (int t = 0; t < 32; t++) begin
            tick(t == 31, t < n_add, r, d);
            if (t < 31) cap[t+1] = so;
        end
    endtask

    logic [31:0] cap;
    logic [31:0] exp_c;

    initial begin
        rst_n    = 1'b0;
        ncen_n   = 1'b1;
        cycle_31 = 1'b0;
        sndadd   = 1'b0;
        rl       = 2'b00;
        op_data  = '0;
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
        sample_cnt = 0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("reset_so", {31'd0, so}, 32'd0);
        rst_n = 1'b1;
        #1;

        // Frame A: 256 on L once. Output during A is the reset-cleared words.
        frame(1, 14'd256, 2'b10, cap);
        check("A_prior_zero", cap, 32'h0000_0000);

        // Frame B: 1000 on L. Capture is A: L m=256 e=1 -> 0x2800; silent R encodes m=0 e=1 -> 0x2000.
        frame(1, 14'd1000, 2'b10, cap);
        check("A_word", cap, 32'h2000_2800);
        check("A_slot11", {31'd0, cap[11]}, 32'd1);
        check("A_slot13", {31'd0, cap[13]}, 32'd1);

        // Frame C: 8 x 8191 on both. Capture is B: L m=500 e=2 -> 0x4FA0.
        frame(8, 14'd8191, 2'b11, cap);
        exp_c = 32'h2000_4FA0;
        for (int i = 0; i < 16; i++) check($sformatf("B_slot%0d", i), {31'd0, cap[i]}, {31'd0, exp_c[i]});
        check("B_word", cap, exp_c);
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
        check("C_emu_l_sat", {16'd0, emu_l}, 32'h0000_7FFF);
        check("C_emu_r_sat", {16'd0, emu_r}, 32'h0000_7FFF);
`endif

        // Frame D: 8 x -8192 on both. Capture is C: 65528 saturates, m=511 e=7 -> 0xEFF8 each side.
        frame(8, 14'h2000, 2'b11, cap);
        check("C_word", cap, 32'hEFF8_EFF8);

        // Frame E: -1234 on R. Capture is D: -65536 saturates, m=0x200 e=7 -> 0xF000 each side.
        sample_reset();
        frame(1, 14'h3B2E, 2'b01, cap);
        check("D_word", cap, 32'hF000_F000);
        for (int i = 0; i < 12; i++) check($sformatf("D_low%0d", i), {31'd0, cap[i]}, 32'd0);
        for (int i = 12; i < 16; i++) check($sformatf("D_high%0d", i), {31'd0, cap[i]}, 32'd1);
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
        check("E_emu_r", {16'd0, emu_r}, 32'h0000_FB2E);
        check("E_emu_l", {16'd0, emu_l}, 32'h0000_0000);
        check("E_sample_cnt", sample_cnt, 32'd1);
`endif

        // Frame F: silent. Capture is E: R 0xFB2E -> m=0x2CB e=3 -> 0x7658; L zero -> 0x2000.
        frame(0, 14'd0, 2'b00, cap);
        check("E_word", cap, 32'h7658_2000);

        // Reset in the middle of a frame carrying partial sums on L.
        for (int t = 0; t < 10; t++) tick(1'b0, 1'b1, 2'b10, 14'd256);
        rst_n = 1'b0;
        #1;
        check("midreset_so", {31'd0, so}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        // Remainder of the disrupted frame: its partial sum must be dropped at the boundary.
        cap = '0;
        for (int t = 0; t < 21; t++) begin
            tick(t == 20, 1'b1, 2'b10, 14'd256);
            cap[t] = so;
        end
        check("post_reset_rem", cap, 32'h0000_0000);
        // Next full frame still serialises the dropped partial frame as zeros.
        frame(1, 14'd256, 2'b10, cap);
        check("post_reset_full", cap, 32'h0000_0000);
        // Only now does the first full post-reset frame appear.
        frame(0, 14'd0, 2'b00, cap);
        check("post_reset_data", cap, 32'h2000_2800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic sample_reset();
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
        sample_cnt = 0;
`endif
    endtask

endmodule
